// File: rtl/gf16_div_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : gf16_div_seq
// Purpose  : Sequential GF(2^4) divider over x^4 + x + 1. Computes
//            q = num / den = num * den^14, using one shared combinational
//            GF(2^4) multiply per cycle (squarings use the same multiply
//            with both operands equal).
// Ports    : clk, rst_n          - clock / asynchronous active-low reset
//            in_valid/in_ready   - operand handshake
//            in_num, in_den      - dividend / divisor (GF(2^4) elements)
//            in_tag              - opaque sideband tag (TAG_W bits)
//            out_valid/out_ready - result handshake, result held until taken
//            out_q, out_tag      - quotient and tag of the producing operation
//            out_dz              - divide-by-zero flag, only present when
//                                  GF16_DIV_ZERO_ERR_EN is defined
// Options  : GF16_DIV_ZERO_ERR_EN - adds out_dz (set when den == 0)
// Revision : 1.0 - initial release
// ============================================================================
module gf16_div_seq #(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_num,
    input  logic [3:0]       in_den,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_q,
    output logic [TAG_W-1:0] out_tag
`ifdef GF16_DIV_ZERO_ERR_EN
    ,
    output logic             out_dz
`endif
);

    // ------------------------------------------------------------------
    // GF(2^4) multiply, shift-and-add with reduction x^4 = x + 1.
    // Bit-identical to the shared combinational multiplier core.
    // ------------------------------------------------------------------
    function automatic logic [3:0] gf16_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] p;
        logic [3:0] t;
        p = 4'h0;
        t = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) begin
                p = p ^ t;
            end
            // t * x, folding the x^4 term back in as x + 1
            t = {t[2:0], 1'b0} ^ (t[3] ? 4'b0011 : 4'b0000);
        end
        return p;
    endfunction

    // ------------------------------------------------------------------
    // State encoding. The exponent chain den -> den^14 is
    // a^2, a^3, a^6, a^7, a^14, followed by the final multiply by num.
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SQ1  = 3'd1,
        ST_M1   = 3'd2,
        ST_SQ2  = 3'd3,
        ST_M2   = 3'd4,
        ST_SQ3  = 3'd5,
        ST_MN   = 3'd6,
        ST_DONE = 3'd7
    } state_t;

    state_t state_q, state_d;

    // Datapath registers
    logic [3:0]       acc_q,   acc_d;
    logic [3:0]       base_q,  base_d;
    logic [3:0]       num_r_q, num_r_d;
    logic [TAG_W-1:0] tag_r_q, tag_r_d;

    // Output registers
    logic             out_valid_q, out_valid_d;
    logic [3:0]       out_q_q,     out_q_d;
    logic [TAG_W-1:0] out_tag_q,   out_tag_d;

    // Shared multiplier operands and product
    logic [3:0] w_mul_a;
    logic [3:0] w_mul_b;
    logic [3:0] w_prod;

    assign w_prod = gf16_mul(w_mul_a, w_mul_b);

`ifdef GF16_DIV_ZERO_ERR_EN
    logic out_dz_q, out_dz_d;
`endif

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            acc_q       <= 4'h0;
            base_q      <= 4'h0;
            num_r_q     <= 4'h0;
            tag_r_q     <= '0;
            out_valid_q <= 1'b0;
            out_q_q     <= 4'h0;
            out_tag_q   <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            base_q      <= base_d;
            num_r_q     <= num_r_d;
            tag_r_q     <= tag_r_d;
            out_valid_q <= out_valid_d;
            out_q_q     <= out_q_d;
            out_tag_q   <= out_tag_d;
        end
    end

`ifdef GF16_DIV_ZERO_ERR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_dz_q <= 1'b0;
        end else begin
            out_dz_q <= out_dz_d;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Next-state, operand selection and output update
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        base_d      = base_q;
        num_r_d     = num_r_q;
        tag_r_d     = tag_r_q;
        out_valid_d = out_valid_q;
        out_q_d     = out_q_q;
        out_tag_d   = out_tag_q;
        w_mul_a     = acc_q;
        w_mul_b     = acc_q;
        in_ready    = 1'b0;
`ifdef GF16_DIV_ZERO_ERR_EN
        out_dz_d    = out_dz_q;
`endif

        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    base_d  = in_den;
                    num_r_d = in_num;
                    tag_r_d = in_tag;
                    state_d = ST_SQ1;
                end
            end

            ST_SQ1: begin
                // a^2
                w_mul_a = base_q;
                w_mul_b = base_q;
                acc_d   = w_prod;
                state_d = ST_M1;
            end

            ST_M1: begin
                // a^3
                w_mul_b = base_q;
                acc_d   = w_prod;
                state_d = ST_SQ2;
            end

            ST_SQ2: begin
                // a^6
                acc_d   = w_prod;
                state_d = ST_M2;
            end

            ST_M2: begin
                // a^7
                w_mul_b = base_q;
                acc_d   = w_prod;
                state_d = ST_SQ3;
            end

            ST_SQ3: begin
                // a^14 = a^-1 for a != 0; a zero divisor stays zero all the
                // way through, so the quotient collapses to 0 naturally.
                acc_d   = w_prod;
                state_d = ST_MN;
            end

            ST_MN: begin
                w_mul_a     = num_r_q;
                out_q_d     = w_prod;
                out_tag_d   = tag_r_q;
                out_valid_d = 1'b1;
`ifdef GF16_DIV_ZERO_ERR_EN
                out_dz_d    = (base_q == 4'h0);
`endif
                state_d     = ST_DONE;
            end

            ST_DONE: begin
                // Result and tag hold until taken; no new accept this cycle.
                if (out_ready) begin
                    out_valid_d = 1'b0;
`ifdef GF16_DIV_ZERO_ERR_EN
                    out_dz_d    = 1'b0;
`endif
                    state_d     = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign out_valid = out_valid_q;
    assign out_q     = out_q_q;
    assign out_tag   = out_tag_q;
`ifdef GF16_DIV_ZERO_ERR_EN
    assign out_dz    = out_dz_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gf16_div_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_gf16_div_seq
// Purpose  : Self-checking bench for gf16_div_seq. Expected results are
//            pushed to a scoreboard queue on accept and popped when the DUT
//            presents a result. Reference arithmetic uses a polynomial
//            multiply with table reduction and a brute-force division search.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gf16_div_seq;

    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_num;
    logic [3:0]       in_den;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       out_q;
    logic [TAG_W-1:0] out_tag;
`ifdef GF16_DIV_ZERO_ERR_EN
    logic             out_dz;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [3:0]       q;
        logic [TAG_W-1:0] tag;
        logic             dz;
    } exp_t;

    exp_t sb[$];

    gf16_div_seq #(.TAG_W(TAG_W)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_num    (in_num),
        .in_den    (in_den),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_q     (out_q),
        .out_tag   (out_tag)
`ifdef GF16_DIV_ZERO_ERR_EN
        ,
        .out_dz    (out_dz)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, obs, exp, $time);
        end
    endtask

    // Polynomial product reduced with x^4=x+1, x^5=x^2+x, x^6=x^3+x^2.
    function automatic logic [3:0] ref_mul(input logic [3:0] a, input logic [3:0] b);
        logic [6:0] p;
        logic [3:0] r;
        p = 7'h0;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) p = p ^ ({3'b000, a} << i);
        end
        r = p[3:0] ^ (p[4] ? 4'h3 : 4'h0) ^ (p[5] ? 4'h6 : 4'h0) ^ (p[6] ? 4'hC : 4'h0);
        return r;
    endfunction

    function automatic logic [3:0] ref_div(input logic [3:0] n, input logic [3:0] d);
        logic [3:0] q;
        if (d == 4'h0) return 4'h0;
        for (int k = 0; k < 16; k++) begin
            q = 4'(k);
            if (ref_mul(q, d) == n) return q;
        end
        return 4'h0;
    endfunction

    // One complete operation. want < 0 selects the reference model,
    // otherwise the given constant is the expected quotient.
    task automatic run_op(input logic [3:0] n, input logic [3:0] d,
                          input logic [TAG_W-1:0] t, input int stall, input int want);
        int   lat;
        int   waitc;
        exp_t e;
        exp_t got;
        waitc = 0;
        while (!in_ready && waitc < 50) begin
            @(posedge clk); #1;
            waitc++;
        end
        check_eq("in_ready_idle", 32'(in_ready), 32'd1);
        in_num    = n;
        in_den    = d;
        in_tag    = t;
        in_valid  = 1'b1;
        out_ready = (stall == 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        e.q   = (want >= 0) ? 4'(want) : ref_div(n, d);
        e.tag = t;
        e.dz  = (d == 4'h0);
        sb.push_back(e);

        lat = 0;
        while (!out_valid && lat < 20) begin
            check_eq("in_ready_busy", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
            lat++;
        end
        check_eq("latency", 32'(lat), 32'd6);
        if (out_valid) begin
            for (int s = 0; s < stall; s++) begin
                in_valid = 1'b1;
                in_num   = ~n;
                in_den   = d + 4'h1;
                in_tag   = ~t;
                @(posedge clk); #1;
                check_eq("stall_valid", 32'(out_valid), 32'd1);
                check_eq("stall_q",     32'(out_q),     32'(e.q));
                check_eq("stall_tag",   32'(out_tag),   32'(e.tag));
                check_eq("stall_ready", 32'(in_ready),  32'd0);
            end
            in_valid = 1'b0;
            if (sb.size() == 0) begin
                check_eq("sb_nonempty", 32'd0, 32'd1);
            end else begin
                got = sb.pop_front();
                check_eq("out_q",   32'(out_q),   32'(got.q));
                check_eq("out_tag", 32'(out_tag), 32'(got.tag));
`ifdef GF16_DIV_ZERO_ERR_EN
                check_eq("out_dz",  32'(out_dz),  32'(got.dz));
`endif
                if (d != 4'h0) check_eq("q_times_den", 32'(ref_mul(out_q, d)), 32'(n));
            end
            out_ready = 1'b1;
            @(posedge clk); #1;
            check_eq("post_hs_valid", 32'(out_valid), 32'd0);
            check_eq("post_hs_ready", 32'(in_ready),  32'd1);
`ifdef GF16_DIV_ZERO_ERR_EN
            check_eq("post_hs_dz",    32'(out_dz),    32'd0);
`endif
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_num    = 4'h0;
        in_den    = 4'h0;
        in_tag    = '0;
        out_ready = 1'b0;
        #12;
        check_eq("rst_in_ready",  32'(in_ready),  32'd1);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_q",     32'(out_q),     32'd0);
        check_eq("rst_out_tag",   32'(out_tag),   32'd0);
`ifdef GF16_DIV_ZERO_ERR_EN
        check_eq("rst_out_dz",    32'(out_dz),    32'd0);
`endif
        #10;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed operations
        run_op(4'h7, 4'h2, 4'h3, 0, 'hA);
        run_op(4'h1, 4'h2, 4'h1, 0, 'h9);
        run_op(4'h1, 4'h3, 4'h2, 0, 'hE);
        run_op(4'h1, 4'h1, 4'h4, 0, 'h1);
        // Divide by zero, then a normal op clears the flag
        run_op(4'h9, 4'h0, 4'h5, 0, 'h0);
        run_op(4'h5, 4'h5, 4'h6, 0, 'h1);
        // Backpressure with ignored in_valid pulses
        run_op(4'hB, 4'h6, 4'hC, 10, -1);

        // Sweep of every (num, den) pair with den != 0
        for (int n = 0; n < 16; n++) begin
            for (int d = 1; d < 16; d++) begin
                run_op(4'(n), 4'(d), 4'(n ^ d), 0, -1);
            end
        end

        // Asynchronous reset while in M2: no output may ever appear
        in_num    = 4'h3;
        in_den    = 4'h7;
        in_tag    = 4'h9;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #4;
        rst_n = 1'b0;
        #1;
        check_eq("arst_out_valid", 32'(out_valid), 32'd0);
        check_eq("arst_in_ready",  32'(in_ready),  32'd1);
        #6;
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            check_eq("arst_no_output", 32'(out_valid), 32'd0);
        end
        run_op(4'h4, 4'h4, 4'h2, 0, 'h1);

        check_eq("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
